// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer: fetches RV32I words and drives ALU/regfile controls for ADD, ADDI and BNE.
// Latency: 4 cycles per instruction minimum (FETCH, DECODE, EXECUTE, PCUPD), plus one cycle per stalled fetch cycle.
// Backpressure: FETCH waits indefinitely for instr_valid; instr_valid is ignored in every other state.
module alu_sequencer #(
  parameter int                    ADDR_WIDTH          = 32,
  parameter int                    DATA_WIDTH          = 32,
  parameter int                    REG_FILE_ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC            = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           instr_req,
  output logic [ADDR_WIDTH-1:0]          instr_addr,
  input  logic                           instr_valid,
  input  logic [DATA_WIDTH-1:0]          instr_data,
  input  logic                           Zero,
  output logic                           ALUsrc,
  output logic                           ALUctrl,
  output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
  output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
  output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
  output logic                           WE3,
  output logic [DATA_WIDTH-1:0]          ImmOp,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic                           illegal
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, PCUPD, ERROR} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] ir;
  logic                  is_bne;
  logic                  taken;

  // Instruction field decode from the latched instruction register
  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  logic                  dec_add, dec_addi, dec_bne, dec_legal;
  logic [DATA_WIDTH-1:0] imm_i, imm_b;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign dec_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign dec_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign dec_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign dec_legal = dec_add || dec_addi || dec_bne;
  assign imm_i     = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
  assign imm_b     = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  // The fetch address is the program counter register itself
  assign instr_addr = pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic; ERROR is only left through reset
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (instr_valid) state_nxt = DECODE;
      DECODE:  state_nxt = dec_legal ? EXECUTE : ERROR;
      EXECUTE: state_nxt = PCUPD;
      PCUPD:   state_nxt = FETCH;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = FETCH;
    endcase
  end

  // Fetch request registered from the next state so it is high in exactly the FETCH cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_req <= 1'b1;
    else        instr_req <= (state_nxt == FETCH);
  end

  // Datapath controls, IR, branch resolution and PC; WE3 defaults low so it pulses for EXECUTE only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir      <= '0;
      pc      <= RESET_PC;
      illegal <= 1'b0;
      WE3     <= 1'b0;
      ALUsrc  <= 1'b0;
      ALUctrl <= 1'b0;
      AD1     <= '0;
      AD2     <= '0;
      AD3     <= '0;
      ImmOp   <= '0;
      is_bne  <= 1'b0;
      taken   <= 1'b0;
    end else begin
      WE3 <= 1'b0;
      case (state)
        FETCH: begin
          if (instr_valid) ir <= instr_data;
        end
        DECODE: begin
          if (dec_legal) begin
            AD1     <= REG_FILE_ADDR_WIDTH'(ir[19:15]);
            AD2     <= REG_FILE_ADDR_WIDTH'(ir[24:20]);
            AD3     <= REG_FILE_ADDR_WIDTH'(ir[11:7]);
            ImmOp   <= dec_addi ? imm_i : (dec_bne ? imm_b : '0);
            ALUsrc  <= dec_addi;
            ALUctrl <= dec_bne;
            is_bne  <= dec_bne;
            // x0 is hardwired, so a write to it is suppressed here
            WE3     <= !dec_bne && (ir[11:7] != 5'd0);
          end else begin
            illegal <= 1'b1;
          end
        end
        EXECUTE: begin
          taken <= is_bne && !Zero;
        end
        PCUPD: begin
          pc <= taken ? pc + ADDR_WIDTH'(ImmOp) : pc + ADDR_WIDTH'(4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed test-plan programs, randomized instruction streams,
// illegal-word lockup and asynchronous reset. Inputs change and outputs are sampled on the falling edge.
module tb_alu_sequencer;
  localparam int K_ADD  = 0;
  localparam int K_ADDI = 1;
  localparam int K_BNE  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        Zero;
  logic        ALUsrc, ALUctrl, WE3, illegal;
  logic [4:0]  AD1, AD2, AD3;
  logic [31:0] ImmOp, pc;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;

  alu_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_FILE_ADDR_WIDTH(5), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data), .Zero(Zero),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .AD1(AD1), .AD2(AD2), .AD3(AD3),
    .WE3(WE3), .ImmOp(ImmOp), .pc(pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Instruction encoders (assembler view of the ISA)
  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    return {7'b0000000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_bne(input int rs1, input int rs2, input int off);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'b001, o[4:1], o[11], 7'b1100011};
  endfunction

  // Runs one legal instruction through the sequencer and checks every phase against the ISA-level model.
  task automatic do_instr(input logic [31:0] w, input int kind, input int imm, input int stall, input logic zero);
    logic [31:0] e_imm, nxt;
    logic        e_we, e_src, e_ctl;
    e_imm = (kind == K_ADD) ? 32'd0 : 32'(imm);
    e_we  = (kind != K_BNE) && (w[11:7] != 5'd0);
    e_src = (kind == K_ADDI);
    e_ctl = (kind == K_BNE);
    nxt   = (kind == K_BNE && !zero) ? exp_pc + 32'(imm) : exp_pc + 32'd4;
    Zero  = ~zero;
    for (int i = 0; i <= stall; i++) begin
      n_tests++;
      if (instr_req !== 1'b1 || instr_addr !== exp_pc || pc !== exp_pc || WE3 !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch[%0d]: req=%b addr=%h pc=%h we3=%b, expected req=1 addr=pc=%h we3=0",
                 i, instr_req, instr_addr, pc, WE3, exp_pc);
      end
      instr_valid = (i == stall);
      instr_data  = (i == stall) ? w : $urandom();
      @(negedge clk);
    end
    // Stray valid with another word during DECODE/EXECUTE/PCUPD must be ignored
    instr_valid = 1'b1;
    instr_data  = 32'hFFFF8F93;
    n_tests++;
    if (instr_req !== 1'b0 || WE3 !== 1'b0) begin
      n_fail++;
      $display("FAIL decode: req=%b we3=%b, expected 0 0", instr_req, WE3);
    end
    @(negedge clk);
    n_tests++;
    if (ALUsrc !== e_src || ALUctrl !== e_ctl || AD1 !== w[19:15] || AD2 !== w[24:20] || AD3 !== w[11:7] ||
        ImmOp !== e_imm || WE3 !== e_we || instr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL execute w=%h: src=%b ctl=%b ad=%0d,%0d,%0d imm=%h we3=%b req=%b, expected src=%b ctl=%b ad=%0d,%0d,%0d imm=%h we3=%b req=0",
               w, ALUsrc, ALUctrl, AD1, AD2, AD3, ImmOp, WE3, instr_req,
               e_src, e_ctl, w[19:15], w[24:20], w[11:7], e_imm, e_we);
    end
    Zero = zero;
    @(negedge clk);
    Zero = ~zero;
    n_tests++;
    if (WE3 !== 1'b0 || instr_req !== 1'b0 || pc !== exp_pc || ALUsrc !== e_src || ALUctrl !== e_ctl ||
        ImmOp !== e_imm || AD3 !== w[11:7]) begin
      n_fail++;
      $display("FAIL pcupd w=%h: we3=%b req=%b pc=%h src=%b ctl=%b imm=%h ad3=%0d, expected 0 0 %h %b %b %h %0d",
               w, WE3, instr_req, pc, ALUsrc, ALUctrl, ImmOp, AD3, exp_pc, e_src, e_ctl, e_imm, w[11:7]);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    exp_pc = nxt;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0; Zero = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (pc !== 32'h0 || illegal !== 1'b0 || WE3 !== 1'b0 || ALUsrc !== 1'b0 || ALUctrl !== 1'b0 ||
        AD1 !== 5'd0 || AD2 !== 5'd0 || AD3 !== 5'd0 || ImmOp !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h ill=%b we3=%b src=%b ctl=%b ad=%0d,%0d,%0d imm=%h, expected all zero",
               pc, illegal, WE3, ALUsrc, ALUctrl, AD1, AD2, AD3, ImmOp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (instr_req !== 1'b1 || instr_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_fetch: req=%b addr=%h, expected 1 00000000", instr_req, instr_addr);
    end
    exp_pc = 32'h0;
  endtask

  task automatic test_directed;
    do_instr(32'h00500513, K_ADDI, 5, 0, 1'b0);          // addi x10,x0,5   pc 0 -> 4
    do_instr(32'h00B50533, K_ADD, 0, 0, 1'b0);           // add x10,x10,x11 pc 4 -> 8
    do_instr(32'hFE051EE3, K_BNE, -4, 0, 1'b0);          // bne taken       pc 8 -> 4
    do_instr(32'h00B50533, K_ADD, 0, 3, 1'b1);           // 3-cycle fetch stall
    do_instr(32'hFE051EE3, K_BNE, -4, 0, 1'b1);          // bne not taken   pc 8 -> 12
    do_instr(32'h00100013, K_ADDI, 1, 0, 1'b0);          // addi x0: no write
    do_instr(enc_bne(1, 0, -20), K_BNE, -20, 1, 1'b0);   // pc 16 -> FFFFFFFC
    do_instr(enc_addi(3, 3, -1), K_ADDI, -1, 0, 1'b0);   // wraps to 0
    n_tests++;
    if (pc !== 32'h0 || instr_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h addr=%h, expected 00000000", pc, instr_addr);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int kind, rd, rs1, rs2, imm, stall;
      logic [31:0] w;
      kind  = $urandom_range(0, 2);
      rd    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      rs1   = $urandom_range(0, 31);
      rs2   = $urandom_range(0, 31);
      stall = $urandom_range(0, 3);
      if (kind == K_ADD) begin
        imm = 0; w = enc_add(rd, rs1, rs2);
      end else if (kind == K_ADDI) begin
        imm = $urandom_range(0, 4095) - 2048; w = enc_addi(rd, rs1, imm);
      end else begin
        imm = ($urandom_range(0, 4095) - 2048) * 2; w = enc_bne(rs1, rs2, imm);
      end
      do_instr(w, kind, imm, stall, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_illegal;
    logic [31:0] bad [4];
    bad[0] = 32'h0000_0000;
    bad[1] = enc_add(5, 6, 7) | 32'h4000_0000;                      // SUB
    bad[2] = enc_bne(1, 2, 8) & ~32'h0000_7000;                     // BEQ
    bad[3] = enc_addi(4, 4, 3) | 32'h0000_2000;                     // SLTI
    for (int k = 0; k < 4; k++) begin
      do_instr(enc_addi(9, 0, 1), K_ADDI, 1, 0, 1'b0);
      instr_valid = 1'b1; instr_data = bad[k];
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 6; c++) begin
        n_tests++;
        if (illegal !== 1'b1 || instr_req !== 1'b0 || pc !== exp_pc || WE3 !== 1'b0) begin
          n_fail++;
          $display("FAIL illegal[%0d] w=%h c=%0d: ill=%b req=%b pc=%h we3=%b, expected 1 0 %h 0",
                   k, bad[k], c, illegal, instr_req, pc, WE3, exp_pc);
        end
        instr_valid = 1'($urandom_range(0, 1));
        instr_data  = 32'h00500513;
        @(negedge clk);
      end
      instr_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (illegal !== 1'b0 || pc !== 32'h0 || instr_req !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_clear[%0d]: ill=%b pc=%h req=%b, expected 0 00000000 1", k, illegal, pc, instr_req);
      end
      exp_pc = 32'h0;
    end
  endtask

  task automatic test_reset_mid_execute;
    do_instr(enc_addi(2, 0, 4), K_ADDI, 4, 0, 1'b0);   // move pc off the reset value
    instr_valid = 1'b1; instr_data = enc_addi(5, 0, 7);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (WE3 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_we3: we3=%b, expected 1", WE3);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (WE3 !== 1'b0 || pc !== 32'h0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: we3=%b pc=%h ill=%b, expected 0 00000000 0", WE3, pc, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (instr_req !== 1'b1 || instr_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL refetch: req=%b addr=%h, expected 1 00000000", instr_req, instr_addr);
    end
    exp_pc = 32'h0;
    do_instr(enc_addi(6, 6, -7), K_ADDI, -7, 2, 1'b0);
    n_tests++;
    if (pc !== 32'h4) begin
      n_fail++;
      $display("FAIL restart_pc: pc=%h, expected 00000004", pc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_reset_mid_execute();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control sequencer that drives the register-file/ALU datapath's control interface: ALUsrc, ALUctrl, AD1/AD2/AD3, WE3 and ImmOp, and consumes its Zero flag. It fetches 32-bit RV32I instruction words over a valid-qualified request interface and decodes ADD, ADDI and BNE. It maintains the program counter, resolves BNE using Zero, and sits between instruction memory and the ALU datapath.

Parameters:
ADDR_WIDTH, 32, program counter / instruction address width
DATA_WIDTH, 32, instruction and immediate width
REG_FILE_ADDR_WIDTH, 5, register address width
RESET_PC, 0, program counter value after reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_req  output  1  fetch request, high only in FETCH
instr_addr  output  ADDR_WIDTH  fetch address, equals pc
instr_valid  input  1  instr_data valid this cycle
instr_data  input  DATA_WIDTH  fetched instruction word
Zero  input  1  datapath zero flag from the ALU result
ALUsrc  output  1  0 = RD2 operand, 1 = ImmOp operand
ALUctrl  output  1  0 = add, 1 = subtract
AD1  output  REG_FILE_ADDR_WIDTH  rs1 address
AD2  output  REG_FILE_ADDR_WIDTH  rs2 address
AD3  output  REG_FILE_ADDR_WIDTH  rd address
WE3  output  1  register write enable
ImmOp  output  DATA_WIDTH  sign-extended immediate
pc  output  ADDR_WIDTH  current program counter
illegal  output  1  sticky illegal-instruction flag

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous) sets:
  - state=FETCH, pc=RESET_PC, illegal=0.
  - WE3=0, ALUsrc=0, ALUctrl=0, AD1=AD2=AD3=0, ImmOp=0.
  - instr_req goes high on the first cycle after rst_n releases.
- Reset asserted mid-instruction aborts the instruction immediately, including dropping WE3 asynchronously.
- States: FETCH, DECODE, EXECUTE, PCUPD, ERROR.
- FETCH:
  - instr_req=1, instr_addr=pc.
  - Wait any number of cycles. On a clock edge with instr_valid=1, latch instr_data into IR and go to DECODE.
  - instr_valid is ignored in every other state.
  - instr_req is low from the cycle after the handshake.
- DECODE:
  - ADD: opcode 0110011, funct3 000, funct7 0000000.
  - ADDI: opcode 0010011, funct3 000.
  - BNE: opcode 1100011, funct3 001.
  - Any other word: set illegal=1 and go to ERROR. The pc is not advanced.
  - Otherwise register AD1=IR[19:15], AD2=IR[24:20], AD3=IR[11:7] and ImmOp, then go to EXECUTE.
  - ADDI immediate: I-type, sign-extended from IR[31].
  - BNE immediate: B-type {IR[31],IR[7],IR[30:25],IR[11:8],0}, sign-extended.
  - ADD: ImmOp=0.
- EXECUTE (exactly one cycle):
  - ADD: ALUsrc=0, ALUctrl=0.
  - ADDI: ALUsrc=1, ALUctrl=0.
  - BNE: ALUsrc=0, ALUctrl=1.
  - WE3=1 for exactly this cycle for ADD/ADDI when AD3!=0. WE3=0 for BNE and whenever AD3=0 (x0 is never written).
  - For BNE, Zero is sampled at the end of EXECUTE into taken = !Zero.
- PCUPD:
  - WE3=0.
  - pc <= pc + ImmOp if BNE and taken, else pc + 4.
  - Arithmetic is modulo 2^ADDR_WIDTH, so wrap-around is silent.
  - Go to FETCH.
- ERROR: terminal until reset. instr_req=0, WE3=0, illegal=1, pc frozen.
- Timing:
  - Minimum 4 cycles per instruction (instr_valid high during the first FETCH cycle).
  - Each cycle instr_valid is delayed adds one cycle.
- ALUsrc, ALUctrl, AD1–AD3 and ImmOp hold their values outside EXECUTE until the next DECODE. Only WE3 carries side effects.

Test Plan:
- ADDI x10,x0,5 (0x00500513), instr_valid immediate -> DECODE: AD3=10, ImmOp=5. EXECUTE: ALUsrc=1, ALUctrl=0, WE3=1 for one cycle. pc 0->4 after 4 cycles; instr_req high again on cycle 5.
- ADD x10,x10,x11 (0x00B50533) -> AD1=10, AD2=11, AD3=10, ALUsrc=0, ALUctrl=0, WE3 pulse one cycle. ADDI x0,x0,1 (0x00100013) -> WE3 stays 0.
- BNE x10,x0,-4 (0xFE051EE3) at pc=8 -> ImmOp=0xFFFFFFFC, ALUctrl=1, WE3=0. With Zero=0 the next pc=4; with Zero=1 the next pc=12.
- Fetch stall: instr_valid held low 3 cycles -> instr_req and instr_addr held stable for 4 cycles. instr_valid pulses in DECODE/EXECUTE/PCUPD are ignored.
- Illegal word 0x00000000 -> illegal=1, instr_req=0 permanently, pc unchanged, WE3 never asserted. Reset clears illegal and restarts at RESET_PC.
- rst_n pulled low during EXECUTE of an ADDI -> WE3 falls without waiting for clk. After release: pc=RESET_PC, first fetch re-issued.
